// File: rtl/phase_request_arbiter_if.sv
// Signal bundle between the intersection arbiter and its surroundings:
// sensor requests and timebase in, lamp codes and status out.
// With PED_WALK_EN defined the bundle also carries ped_req and walk.
interface phase_request_arbiter_if;
   logic       tick;
   logic [3:0] req;
   logic [2:0] light_n;
   logic [2:0] light_e;
   logic [2:0] light_s;
   logic [2:0] light_w;
   logic [3:0] grant;
   logic [3:0] pending;
   logic       busy;
`ifdef PED_WALK_EN
   logic       ped_req;
   logic       walk;
`endif

   // Arbiter side: consumes requests and timebase, drives lamps and status.
   modport master (
      input  tick,
      input  req,
`ifdef PED_WALK_EN
      input  ped_req,
      output walk,
`endif
      output light_n,
      output light_e,
      output light_s,
      output light_w,
      output grant,
      output pending,
      output busy
   );

   // Environment side: sensor front end and lamp drivers.
   modport slave (
      output tick,
      output req,
`ifdef PED_WALK_EN
      output ped_req,
      input  walk,
`endif
      input  light_n,
      input  light_e,
      input  light_s,
      input  light_w,
      input  grant,
      input  pending,
      input  busy
   );
endinterface

// File: rtl/phase_request_arbiter.sv
// Demand-actuated four-approach intersection arbiter.
// Latches N/E/S/W requests, grants green round-robin, and sequences
// GREEN -> YELLOW -> ALL_RED clearance between grants. Timers advance only
// on the shared tick strobe; all outputs are registered.
// Optional pedestrian WALK phase is enabled by defining PED_WALK_EN.
module phase_request_arbiter #(
   parameter int unsigned MIN_GREEN   = 20,
   parameter int unsigned MAX_GREEN   = 50,
   parameter int unsigned YELLOW_TIME = 10,
   parameter int unsigned ALLRED_TIME = 4,
`ifdef PED_WALK_EN
   parameter int unsigned WALK_TIME   = 15,
`endif
   parameter int unsigned TIMER_W     = 7
) (
   input logic                     clk,
   input logic                     reset_n,
   phase_request_arbiter_if.master bus
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_GREEN   = 3'd1;
   localparam logic [2:0] S_YELLOW  = 3'd2;
   localparam logic [2:0] S_ALL_RED = 3'd3;
`ifdef PED_WALK_EN
   localparam logic [2:0] S_WALK    = 3'd4;
`endif

   localparam logic [2:0] LAMP_RED    = 3'b100;
   localparam logic [2:0] LAMP_YELLOW = 3'b010;
   localparam logic [2:0] LAMP_GREEN  = 3'b001;

   localparam logic [TIMER_W-1:0] MIN_LAST = TIMER_W'(MIN_GREEN - 1);
   localparam logic [TIMER_W-1:0] MAX_LAST = TIMER_W'(MAX_GREEN - 1);
   localparam logic [TIMER_W-1:0] YEL_LAST = TIMER_W'(YELLOW_TIME - 1);
   localparam logic [TIMER_W-1:0] AR_LAST  = TIMER_W'(ALLRED_TIME - 1);
`ifdef PED_WALK_EN
   localparam logic [TIMER_W-1:0] WALK_LAST = TIMER_W'(WALK_TIME - 1);
`endif

   logic [2:0]         state, state_d;
   logic [TIMER_W-1:0] timer, timer_d;
   logic [3:0]         pending_q, pending_d;
   logic [3:0]         grant_q, grant_d;
   logic [1:0]         rr_ptr, rr_d;
   logic [3:0]         clear_mask;
   logic [3:0][2:0]    light_q;
   logic               busy_q;

   logic               sel_found;
   logic [1:0]         sel_idx;
   logic [1:0]         cand;
   logic [3:0]         sel_onehot;
   logic               other_pending;
   logic               green_start;

`ifdef PED_WALK_EN
   logic               ped_pending_q, ped_pending_d;
   logic               ped_clear;
   logic               walk_start;
   logic               walk_q;
`endif

   // Lamp code for one approach given the phase it will be in and its grant bit.
   function automatic logic [2:0] lamp_code(input logic [2:0] st, input logic granted);
      logic [2:0] code;
      code = LAMP_RED;
      if (granted && (st == S_GREEN)) begin
         code = LAMP_GREEN;
      end else if (granted && (st == S_YELLOW)) begin
         code = LAMP_YELLOW;
      end
      return code;
   endfunction

   // Round-robin search: first pending approach after rr_ptr, wrapping modulo 4.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = rr_ptr;
      cand      = rr_ptr;
      for (int unsigned k = 1; k <= 4; k++) begin
         cand = rr_ptr + 2'(k);
         if (!sel_found && pending_q[cand]) begin
            sel_found = 1'b1;
            sel_idx   = cand;
         end
      end
      sel_onehot = 4'b0001 << sel_idx;
   end

   // A competing demand is anything latched other than the approach holding green.
`ifdef PED_WALK_EN
   assign other_pending = (|(pending_q & ~grant_q)) | ped_pending_q;
`else
   assign other_pending = |(pending_q & ~grant_q);
`endif

   // Phase sequencing and timer control; every phase except IDLE waits on tick.
   always_comb begin
      state_d     = state;
      timer_d     = timer;
      grant_d     = grant_q;
      rr_d        = rr_ptr;
      clear_mask  = '0;
      green_start = 1'b0;
`ifdef PED_WALK_EN
      ped_clear   = 1'b0;
      walk_start  = 1'b0;
`endif
      case (state)
         S_IDLE: begin
`ifdef PED_WALK_EN
            if (ped_pending_q) walk_start = 1'b1;
            else
`endif
            if (sel_found) green_start = 1'b1;
         end
         S_GREEN: begin
            if (bus.tick) begin
               if (other_pending && (timer >= MIN_LAST)) begin
                  state_d = S_YELLOW;
                  timer_d = '0;
               end else if (timer < MAX_LAST) begin
                  timer_d = timer + TIMER_W'(1);
               end
            end
         end
         S_YELLOW: begin
            if (bus.tick) begin
               if (timer >= YEL_LAST) begin
                  state_d = S_ALL_RED;
                  timer_d = '0;
                  grant_d = '0;
               end else begin
                  timer_d = timer + TIMER_W'(1);
               end
            end
         end
         S_ALL_RED: begin
            if (bus.tick) begin
               if (timer >= AR_LAST) begin
                  timer_d = '0;
`ifdef PED_WALK_EN
                  if (ped_pending_q) walk_start = 1'b1;
                  else
`endif
                  if (sel_found) green_start = 1'b1;
                  else state_d = S_IDLE;
               end else begin
                  timer_d = timer + TIMER_W'(1);
               end
            end
         end
`ifdef PED_WALK_EN
         S_WALK: begin
            if (bus.tick) begin
               if (timer >= WALK_LAST) begin
                  state_d = S_ALL_RED;
                  timer_d = '0;
               end else begin
                  timer_d = timer + TIMER_W'(1);
               end
            end
         end
`endif
         default: begin
            state_d = S_ALL_RED;
            timer_d = '0;
            grant_d = '0;
         end
      endcase

      if (green_start) begin
         state_d    = S_GREEN;
         timer_d    = '0;
         grant_d    = sel_onehot;
         rr_d       = sel_idx;
         clear_mask = sel_onehot;
      end
`ifdef PED_WALK_EN
      if (walk_start) begin
         state_d   = S_WALK;
         timer_d   = '0;
         grant_d   = '0;
         ped_clear = 1'b1;
      end
`endif
   end

   // Request latch: the granted approach is deaf, and a grant clear beats a new set.
   assign pending_d = (pending_q | (bus.req & ~grant_q)) & ~clear_mask;
`ifdef PED_WALK_EN
   assign ped_pending_d = (ped_pending_q | bus.ped_req) & ~ped_clear;
`endif

   // State, timer, latch and round-robin pointer registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= S_IDLE;
         timer     <= '0;
         pending_q <= '0;
         grant_q   <= '0;
         rr_ptr    <= 2'd3;
      end else begin
         state     <= state_d;
         timer     <= timer_d;
         pending_q <= pending_d;
         grant_q   <= grant_d;
         rr_ptr    <= rr_d;
      end
   end

   // Lamp and busy outputs registered from the next phase so they align with grant.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < 4; i++) begin
            light_q[i] <= LAMP_RED;
         end
         busy_q <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < 4; i++) begin
            light_q[i] <= lamp_code(state_d, grant_d[i]);
         end
         busy_q <= (state_d != S_IDLE);
      end
   end

`ifdef PED_WALK_EN
   // Pedestrian request latch and walk indicator.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ped_pending_q <= 1'b0;
         walk_q        <= 1'b0;
      end else begin
         ped_pending_q <= ped_pending_d;
         walk_q        <= (state_d == S_WALK);
      end
   end

   assign bus.walk = walk_q;
`endif

   assign bus.light_n = light_q[0];
   assign bus.light_e = light_q[1];
   assign bus.light_s = light_q[2];
   assign bus.light_w = light_q[3];
   assign bus.grant   = grant_q;
   assign bus.pending = pending_q;
   assign bus.busy    = busy_q;

endmodule

// File: tb/tb_phase_request_arbiter.sv
// Directed bench for phase_request_arbiter (default build, PED_WALK_EN undefined).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_phase_request_arbiter;

   localparam logic [2:0] RED = 3'b100;
   localparam logic [2:0] YEL = 3'b010;
   localparam logic [2:0] GRN = 3'b001;

   logic clk;
   logic reset_n;
   int   checks;
   int   passes;

   phase_request_arbiter_if bus ();

   phase_request_arbiter #(
      .MIN_GREEN  (20),
      .MAX_GREEN  (50),
      .YELLOW_TIME(10),
      .ALLRED_TIME(4),
      .TIMER_W    (7)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Expected {w,s,e,n} lamp word: approach idx shows code, others red; idx<0 = all red.
   function automatic logic [11:0] lamps(input int idx, input logic [2:0] code);
      logic [11:0] v;
      v = {RED, RED, RED, RED};
      if (idx >= 0) v[idx*3 +: 3] = code;
      return v;
   endfunction

   function automatic logic [3:0] onehot(input int idx);
      logic [3:0] v;
      v = '0;
      if (idx >= 0) v[idx] = 1'b1;
      return v;
   endfunction

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic [15:0] view();
      return {bus.grant, bus.light_w, bus.light_s, bus.light_e, bus.light_n};
   endfunction

   // Check lamps+grant for n consecutive cycles, advancing one cycle after each.
   task automatic expect_cycles(input string tag, input int n, input int idx,
                                input logic [2:0] code);
      logic [3:0] g;
      g = (code == RED) ? 4'b0000 : onehot(idx);
      for (int i = 0; i < n; i++) begin
         check(tag, view(), {g, lamps(idx, code)});
         cyc(1);
      end
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      bus.req = 4'b0000;
      bus.tick = 1'b1;
      cyc(1);
      reset_n = 1'b1;
      cyc(1);
   endtask

   initial begin
      checks   = 0;
      passes   = 0;
      reset_n  = 1'b0;
      bus.tick = 1'b1;
      bus.req  = 4'b0000;
`ifdef PED_WALK_EN
      bus.ped_req = 1'b0;
`endif
      cyc(2);

      // Reset state
      check("reset_view", view(), {4'b0000, lamps(-1, RED)});
      check("reset_pend_busy", {11'd0, bus.pending, bus.busy}, 16'd0);
      reset_n = 1'b1;
      cyc(10);
      check("idle_view", view(), {4'b0000, lamps(-1, RED)});
      check("idle_busy", {15'd0, bus.busy}, 16'd0);

      // Single N pulse: latched after one edge, green after the second
      bus.req = 4'b0001;
      cyc(1);
      bus.req = 4'b0000;
      check("n_latched", {12'd0, bus.pending}, 16'h0001);
      check("n_not_yet", view(), {4'b0000, lamps(-1, RED)});
      cyc(1);
      check("n_green", view(), {4'b0001, lamps(0, GRN)});
      check("n_busy_pend", {11'd0, bus.pending, bus.busy}, 16'h0001);
      cyc(100);
      check("n_rests", view(), {4'b0001, lamps(0, GRN)});

      // Late E request with tick held low: green holds until the next tick
      bus.tick = 1'b0;
      bus.req  = 4'b0010;
      cyc(1);
      bus.req = 4'b0000;
      check("e_latched", {12'd0, bus.pending}, 16'h0002);
      cyc(5);
      check("tick_hold", view(), {4'b0001, lamps(0, GRN)});
      bus.tick = 1'b1;
      cyc(1);
      expect_cycles("late_n_yel", 10, 0, YEL);
      expect_cycles("late_allred", 4, -1, RED);
      check("late_e_green", view(), {4'b0010, lamps(1, GRN)});
      check("late_pend", {12'd0, bus.pending}, 16'h0000);

      // N green, E pulsed at timer=5: green still lasts MIN_GREEN ticks
      do_reset();
      bus.req = 4'b0001;
      cyc(1);
      bus.req = 4'b0000;
      cyc(1);
      expect_cycles("t5_n_grn_a", 5, 0, GRN);
      bus.req = 4'b0010;
      expect_cycles("t5_n_grn_b", 1, 0, GRN);
      bus.req = 4'b0000;
      check("t5_e_pend", {12'd0, bus.pending}, 16'h0002);
      expect_cycles("t5_n_grn_c", 14, 0, GRN);
      expect_cycles("t5_n_yel", 10, 0, YEL);
      expect_cycles("t5_allred", 4, -1, RED);
      check("t5_e_green", view(), {4'b0010, lamps(1, GRN)});

      // All requests held: N,E,S,W,N with 20/10/4 tick phases
      do_reset();
      bus.req = 4'b1111;
      cyc(2);
      check("rr_pend", {12'd0, bus.pending}, 16'h000E);
      for (int a = 0; a < 4; a++) begin
         expect_cycles("rr_green", 20, a, GRN);
         expect_cycles("rr_yellow", 10, a, YEL);
         expect_cycles("rr_allred", 4, -1, RED);
      end
      check("rr_wrap_n", view(), {4'b0001, lamps(0, GRN)});
      bus.req = 4'b0000;

      // Asynchronous reset in the middle of N green
      do_reset();
      bus.req = 4'b0001;
      cyc(1);
      bus.req = 4'b0100;
      cyc(1);
      bus.req = 4'b0000;
      check("ar_pre_green", view(), {4'b0001, lamps(0, GRN)});
      check("ar_pre_pend", {12'd0, bus.pending}, 16'h0004);
      cyc(3);
      #2;
      reset_n = 1'b0;
      #1;
      check("ar_view", view(), {4'b0000, lamps(-1, RED)});
      check("ar_pend_busy", {11'd0, bus.pending, bus.busy}, 16'd0);
      @(negedge clk);
      reset_n = 1'b1;
      cyc(3);
      check("ar_idle", view(), {4'b0000, lamps(-1, RED)});
      check("ar_idle_busy", {15'd0, bus.busy}, 16'd0);

      // After reset, E and W together: E first (pointer starts at W), then W
      bus.req = 4'b1010;
      cyc(1);
      bus.req = 4'b0000;
      check("ew_latched", {12'd0, bus.pending}, 16'h000A);
      cyc(1);
      check("ew_pend", {12'd0, bus.pending}, 16'h0008);
      expect_cycles("ew_e_green", 20, 1, GRN);
      expect_cycles("ew_e_yel", 10, 1, YEL);
      expect_cycles("ew_allred", 4, -1, RED);
      check("ew_w_green", view(), {4'b1000, lamps(3, GRN)});
      check("ew_w_pend", {12'd0, bus.pending}, 16'h0000);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
